// File: rtl/switch_pkg.sv
// switch_pkg: shared FSM states, length limits and port-index width for the switch arbiter.
package switch_pkg;
    typedef enum logic [1:0] {IDLE, SEND, ACK} state_t;
    localparam int MIN_LEN_DEF = 64;
    localparam int MAX_LEN_DEF = 1518;
    localparam int PORT_W = 2;
endpackage

// File: rtl/switch_arb_rr_pick.sv
// rr_pick: combinational round-robin pick, first requester at or after ptr with wraparound.
module rr_pick
    import switch_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    ptr,
    output logic [PORT_W-1:0]    win,
    output logic                 hit
);
    logic [PORT_W-1:0] p;
    always_comb begin
        win = '0;
        hit = 1'b0;
        p = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            p = PORT_W'((int'(ptr) + i) % NUM_PORTS);
            if (req[p]) begin
                win = p;
                hit = 1'b1;
            end
        end
    end
endmodule

// File: rtl/switch_arb.sv
// switch_arb: round-robin arbiter handing one MAC packet header at a time to the forwarding engine,
// dropping packets with illegal length and counting drops per port.
module switch_arb
    import switch_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int MIN_LEN   = MIN_LEN_DEF,
    parameter int MAX_LEN   = MAX_LEN_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        mac_arb_valid,
    input  logic [NUM_PORTS-1:0][11:0]  mac_pkt_len,
    input  logic [NUM_PORTS-1:0][255:0] mac_fe_data,
    output logic [NUM_PORTS-1:0]        arb_mac_rdy,
    output logic                        fe_valid,
    input  logic                        fe_rdy,
    output logic [PORT_W-1:0]           fe_port,
    output logic [11:0]                 fe_pkt_len,
    output logic [255:0]                fe_hdr,
    output logic [NUM_PORTS-1:0][15:0]  drop_cnt
);
    state_t state, state_nx;
    logic [PORT_W-1:0] rr_ptr, win;
    logic [NUM_PORTS-1:0] req, win_oh;
    logic hit, mask, bad, take;

    // fe_port doubles as the latched winner; mask hides it for one IDLE cycle after its ACK
    assign win_oh = NUM_PORTS'(1) << fe_port;
    assign req = mac_arb_valid & ~(mask ? win_oh : '0);
    assign bad = int'(mac_pkt_len[win]) < MIN_LEN || int'(mac_pkt_len[win]) > MAX_LEN;
    assign take = state == IDLE && hit;
    assign fe_valid = state == SEND;
    assign arb_mac_rdy = state == ACK ? win_oh : '0;

    rr_pick #(.NUM_PORTS(NUM_PORTS)) u_pick (
        .req(req),
        .ptr(rr_ptr),
        .win(win),
        .hit(hit)
    );

    always_comb begin
        state_nx = state;
        if (take) state_nx = bad ? ACK : SEND;
        else if (state == SEND && fe_rdy) state_nx = ACK;
        else if (state == ACK) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            mask <= 1'b0;
            fe_port <= '0;
            fe_pkt_len <= '0;
            fe_hdr <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_nx;
            mask <= state == ACK;
            if (take) begin
                fe_port <= win;
                fe_pkt_len <= mac_pkt_len[win];
                fe_hdr <= mac_fe_data[win];
                if (bad && drop_cnt[win] != 16'hFFFF) drop_cnt[win] <= drop_cnt[win] + 16'd1;
            end
            if (state == ACK) rr_ptr <= PORT_W'((int'(fe_port) + 1) % NUM_PORTS);
        end
    end
endmodule

// File: tb/tb_switch_arb.sv
// tb_switch_arb: directed scoreboard bench for switch_arb.
module tb_switch_arb;
    logic clk = 0, reset = 1, fe_rdy = 0, fe_valid;
    logic [3:0] mac_arb_valid = '0, arb_mac_rdy;
    logic [3:0][11:0] mac_pkt_len = '0;
    logic [3:0][255:0] mac_fe_data = '0;
    logic [1:0] fe_port;
    logic [11:0] fe_pkt_len;
    logic [255:0] fe_hdr;
    logic [3:0][15:0] drop_cnt;

    typedef struct {
        int port;
        int len;
        logic [255:0] hdr;
        bit drop;
    } exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0;
    bit hold_req = 0;

    switch_arb dut (
        .clk(clk), .reset(reset), .mac_arb_valid(mac_arb_valid), .mac_pkt_len(mac_pkt_len),
        .mac_fe_data(mac_fe_data), .arb_mac_rdy(arb_mac_rdy), .fe_valid(fe_valid), .fe_rdy(fe_rdy),
        .fe_port(fe_port), .fe_pkt_len(fe_pkt_len), .fe_hdr(fe_hdr), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1;
        fe_rdy = 0;
        hold_req = 0;
        mac_arb_valid = '0;
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic set_req(int p, int len);
        mac_arb_valid[p] = 1'b1;
        mac_pkt_len[p] = 12'(len);
        mac_fe_data[p] = {8{$urandom}};
    endtask

    task automatic expect_grant(int p);
        exp_t e;
        e.port = p;
        e.len = int'(mac_pkt_len[p]);
        e.hdr = mac_fe_data[p];
        e.drop = e.len < 64 || e.len > 1518;
        sb.push_back(e);
    endtask

    task automatic wait_fe();
        int n = 0;
        while (fe_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fe_valid_wait_bound", n < 20, 1);
    endtask

    // pops the next expected grant and follows it through offer and acknowledge (fe_rdy high)
    task automatic consume();
        exp_t e;
        int n = 0;
        e = sb.pop_front();
        while (fe_valid !== 1'b1 && arb_mac_rdy === 4'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("grant_wait_bound", n < 20, 1);
        if (!e.drop) begin
            check("fe_valid", fe_valid, 1);
            check("fe_port", fe_port, e.port);
            check("fe_pkt_len", fe_pkt_len, e.len);
            check("fe_hdr", fe_hdr, e.hdr);
            @(negedge clk);
        end
        check("fe_valid_in_ack", fe_valid, 0);
        check("ack", arb_mac_rdy, 4'b1 << e.port);
        if (!hold_req) mac_arb_valid[e.port] = 1'b0;
        @(negedge clk);
        check("ack_once", arb_mac_rdy, 0);
    endtask

    initial begin
        exp_t e;
        int acks, cyc;
        bit saw_fe;

        do_reset();
        check("rst_fe_valid", fe_valid, 0);
        check("rst_arb_mac_rdy", arb_mac_rdy, 0);
        check("rst_fe_port", fe_port, 0);
        check("rst_fe_pkt_len", fe_pkt_len, 0);
        check("rst_fe_hdr", fe_hdr, 0);
        check("rst_drop_cnt", drop_cnt, 0);

        // single request on port 2, fe_rdy tied high
        fe_rdy = 1;
        set_req(2, 100);
        expect_grant(2);
        @(negedge clk);
        check("t1_latency", fe_valid, 1);
        consume();

        // all four ports requesting continuously from reset
        reset = 1;
        mac_arb_valid = '0;
        for (int p = 0; p < 4; p++) set_req(p, 64);
        repeat (2) @(negedge clk);
        reset = 0;
        fe_rdy = 1;
        hold_req = 1;
        for (int k = 0; k < 5; k++) expect_grant(k % 4);
        for (int k = 0; k < 5; k++) consume();

        // length-error drops on ports 1 and 3
        do_reset();
        fe_rdy = 1;
        set_req(1, 40);
        set_req(3, 2000);
        expect_grant(1);
        expect_grant(3);
        consume();
        consume();
        check("t3_drop1", drop_cnt[1], 1);
        check("t3_drop3", drop_cnt[3], 1);
        check("t3_drop0", drop_cnt[0], 0);

        // fe_rdy held low for 10 cycles; inputs change underneath the latched transfer
        do_reset();
        set_req(1, 500);
        expect_grant(1);
        e = sb.pop_front();
        @(negedge clk);
        check("t4_latency", fe_valid, 1);
        mac_pkt_len[1] = 12'd77;
        mac_fe_data[1] = ~mac_fe_data[1];
        set_req(0, 64);
        for (int k = 0; k < 10; k++) begin
            check("t4_hold_valid", fe_valid, 1);
            check("t4_hold_port", fe_port, e.port);
            check("t4_hold_len", fe_pkt_len, e.len);
            check("t4_hold_hdr", fe_hdr, e.hdr);
            check("t4_no_ack", arb_mac_rdy, 0);
            @(negedge clk);
        end
        fe_rdy = 1;
        @(negedge clk);
        check("t4_ack", arb_mac_rdy, 4'b0010);

        // reset mid-SEND abandons the transfer
        do_reset();
        fe_rdy = 1;
        set_req(3, 10);
        expect_grant(3);
        consume();
        check("t5_pre_drop3", drop_cnt[3], 1);
        fe_rdy = 0;
        set_req(2, 100);
        wait_fe();
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("t5_fe_valid", fe_valid, 0);
        check("t5_no_ack", arb_mac_rdy, 0);
        check("t5_drop_cnt", drop_cnt, 0);
        check("t5_fe_port", fe_port, 0);
        set_req(0, 64);
        fe_rdy = 1;
        expect_grant(0);
        expect_grant(2);
        consume();
        consume();

        // back-to-back drops on port 0 saturate the counter
        do_reset();
        set_req(0, 10);
        hold_req = 1;
        acks = 0;
        cyc = 0;
        saw_fe = 0;
        while (acks < 65540 && cyc < 65540 * 3 + 100) begin
            @(negedge clk);
            cyc++;
            if (fe_valid) saw_fe = 1;
            if (arb_mac_rdy[0]) begin
                acks++;
                if (acks == 1 || acks == 65534 || acks == 65535) check("t6_drop_count", drop_cnt[0], acks);
            end
        end
        check("t6_acks", acks, 65540);
        check("t6_saturated", drop_cnt[0], 16'hFFFF);
        check("t6_no_fe_valid", saw_fe, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/switch_arb.md
SWITCH_ARB -- requirements
Module: switch_arb

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, the number of MAC ports arbitrated.
REQ-002 The block SHALL have parameter MIN_LEN, default 64, the minimum legal packet length in bytes.
REQ-003 The block SHALL have parameter MAX_LEN, default 1518, the maximum legal packet length in bytes.
REQ-004 The block SHALL have port clk  input  1  clock, all logic on its rising edge.
REQ-005 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port mac_arb_valid  input  NUM_PORTS  per-port request; the packet in that MAC is ready for forwarding.
REQ-007 The block SHALL have port mac_pkt_len  input  NUM_PORTS x 12  per-port packet length in bytes.
REQ-008 The block SHALL have port mac_fe_data  input  NUM_PORTS x 256  per-port first 32 bytes of the packet (header).
REQ-009 The block SHALL have port arb_mac_rdy  output  NUM_PORTS  per-port one-cycle acknowledge; the request is consumed.
REQ-010 The block SHALL have port fe_valid  output  1  a forwarding-engine transfer is offered.
REQ-011 The block SHALL have port fe_rdy  input  1  the forwarding engine accepts the offered transfer.
REQ-012 The block SHALL have port fe_port  output  2  source port of the offered packet.
REQ-013 The block SHALL have port fe_pkt_len  output  12  length of the offered packet.
REQ-014 The block SHALL have port fe_hdr  output  256  header of the offered packet.
REQ-015 The block SHALL have port drop_cnt  output  NUM_PORTS x 16  per-port count of length-error drops.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SEND, ACK.
REQ-017 IDLE SHALL select a winner when any mac_arb_valid bit is set: round-robin, search starting at rr_ptr and wrapping through NUM_PORTS-1 to 0.
REQ-018 On selection, the block SHALL latch the winner's index, mac_pkt_len and mac_fe_data into holding registers; the fe_* outputs SHALL drive only these registers.
REQ-019 If the latched length is less than MIN_LEN or greater than MAX_LEN, IDLE SHALL go to ACK and increment that port's drop_cnt; otherwise IDLE SHALL go to SEND.
REQ-020 drop_cnt SHALL saturate at 16'hFFFF.
REQ-021 SEND SHALL hold fe_valid=1 with stable fe_port, fe_pkt_len and fe_hdr until the first cycle in which fe_rdy=1, then go to ACK.
REQ-022 fe_rdy SHALL be ignored outside SEND.
REQ-023 ACK SHALL assert arb_mac_rdy[winner]=1 for exactly one cycle, set rr_ptr = (winner+1) mod NUM_PORTS, and return to IDLE.
REQ-024 At most one arb_mac_rdy bit SHALL be high in any cycle.
REQ-025 The block SHALL ignore the winner's mac_arb_valid during the ACK cycle and the following IDLE cycle, so a MAC that deasserts one cycle after the acknowledge is not granted twice.
REQ-026 Latency SHALL be: request sampled in IDLE at cycle N, fe_valid=1 at cycle N+1; fe_rdy at cycle M, arb_mac_rdy at cycle M+1.
REQ-027 Changes to a port's mac_arb_valid, length or header while that port is not selected SHALL have no effect; after selection, input changes SHALL not alter the latched values.
REQ-028 A request deasserted before selection SHALL be lost silently.
REQ-029 When several requests are simultaneous, exactly one SHALL be granted per IDLE pass.
REQ-030 Each requesting port SHALL be granted within NUM_PORTS grants.

Reset
REQ-031 When reset=1 at a clock edge, the block SHALL go to IDLE and clear rr_ptr, fe_valid, arb_mac_rdy, fe_port, fe_pkt_len, fe_hdr and all drop_cnt.
REQ-032 Reset SHALL take priority over every other event, including mid-SEND or ACK; an abandoned transfer SHALL not be acknowledged.

Structure
REQ-033 The state enum, MIN_LEN/MAX_LEN defaults and the port-index width SHALL reside in the shared package switch_pkg.
REQ-034 The round-robin winner selection SHALL be a combinational sub-module rr_pick (inputs: request vector and rr_ptr; outputs: winner index and any-valid).

Verification
REQ-035 The bench SHALL cover: a single request on port 2 with length 100 and fe_rdy tied high -> fe_valid one cycle after the request; fe_port=2, fe_pkt_len=100; arb_mac_rdy=4'b0100 for one cycle.
REQ-036 The bench SHALL cover: all four ports requesting continuously from reset, each with length 64 -> grant order 0,1,2,3,0.
REQ-037 The bench SHALL cover: port 1 with length 40 and port 3 with length 2000 -> no fe_valid; both acknowledged; drop_cnt[1]=1 and drop_cnt[3]=1.
REQ-038 The bench SHALL cover: fe_rdy low for 10 cycles during SEND -> fe_valid and the fe_* outputs stable for all 10 cycles; acknowledge only after fe_rdy rises.
REQ-039 The bench SHALL cover: reset asserted mid-SEND -> next cycle fe_valid=0, no arb_mac_rdy, drop_cnt=0; port 0 wins first after reset.
REQ-040 The bench SHALL cover: 65540 back-to-back drops on port 0 -> drop_cnt[0]=16'hFFFF with no wrap.
